pipe_elastic_reg: RTL and testbench
===================================

PIPE_ELASTIC_REG -- requirements
Module: pipe_elastic_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 512, giving the payload width in bits (one packed inter-stage bundle).
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the number of buffered entries; legal range is 1..8, and non-power-of-two values SHALL be supported.
REQ-003 The block SHALL have derived parameter CW = $clog2(DEPTH+1), giving the occupancy counter width.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port in_valid, input, 1 bit: the upstream stage offers a beat.
REQ-007 Port in_data, input, WIDTH bits: the upstream payload.
REQ-008 Port in_ready, output, 1 bit: the block can accept a beat this cycle.
REQ-009 Port out_valid, output, 1 bit: the head entry is valid for the downstream stage.
REQ-010 Port out_data, output, WIDTH bits: the head entry payload.
REQ-011 Port out_ready, input, 1 bit: the downstream stage consumes the head this cycle.
REQ-012 Port flush, input, 1 bit: discard all buffered and incoming beats (branch mispredict / kill).
REQ-013 Port count, output, CW bits: the current occupancy.

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH entries with read pointer rd_ptr, write pointer wr_ptr and occupancy count.
REQ-015 Push SHALL occur when in_valid && in_ready && !flush; the entry is written at wr_ptr.
REQ-016 Pop SHALL occur when out_valid && out_ready && !flush; rd_ptr advances.
REQ-017 Each pointer SHALL wrap from DEPTH-1 to 0 on advance.
REQ-018 in_ready SHALL be (count < DEPTH) && !rst, and SHALL have no combinational dependence on out_ready or in_valid.
REQ-019 out_valid SHALL be (count != 0).
REQ-020 out_data SHALL equal the entry at rd_ptr when out_valid=1 and SHALL be all zeros when out_valid=0.
REQ-021 Latency SHALL be one cycle: a beat pushed in cycle N is presented with out_valid=1 in cycle N+1 if the buffer was empty.
REQ-022 No combinational path from in_data to out_data SHALL exist.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-024 Push alone SHALL increment count; pop alone SHALL decrement count.
REQ-025 When full (count==DEPTH), in_ready SHALL be 0 even if out_ready=1, so no push occurs that cycle.
REQ-026 DEPTH=1 SHALL therefore sustain at most one beat per two cycles.
REQ-027 DEPTH>=2 SHALL sustain one beat per cycle when out_ready is held at 1.
REQ-028 Once out_valid=1, out_data SHALL hold stable until a pop or flush occurs; a stalled head SHALL never change.
REQ-029 Flush SHALL take priority over push and pop: the next cycle has count=0, rd_ptr=0, wr_ptr=0 and out_valid=0, and the beat offered in the flush cycle is dropped.
REQ-030 in_ready during the flush cycle SHALL follow REQ-018 (pre-flush count).
REQ-031 Beats already accepted SHALL be delivered exactly once, in order; none SHALL be duplicated, reordered or lost unless flushed.
REQ-032 Buffer storage contents SHALL NOT require reset; only the pointers and count are reset.

Reset
REQ-033 While rst=1 at a rising edge, the next state SHALL be count=0, rd_ptr=0 and wr_ptr=0; any beat offered is ignored and no pop occurs.
REQ-034 During and after reset the outputs SHALL be out_valid=0, out_data=0 and count=0.
REQ-035 in_ready SHALL be 0 while rst=1 and SHALL be 1 in the first cycle after rst falls.
REQ-036 Reset asserted mid-operation with a full buffer SHALL discard all entries in the same manner as flush.
REQ-037 rst SHALL take priority over flush.

Verification
REQ-038 Scenario streaming: DEPTH=2, out_ready=1, push 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 on consecutive cycles starting one cycle after the first push, with count never exceeding 1.
REQ-039 Scenario backpressure: DEPTH=3, out_ready=0, push 0xA,0xB,0xC,0xD -> count=3, in_ready=0, 0xD not accepted, out_data stays 0xA; then out_ready=1 -> 0xA,0xB,0xC in order.
REQ-040 Scenario wrap: DEPTH=3, run 10 alternating push-only/pop-only and push+pop cycles -> pointers wrap 2->0 and the output sequence matches the input sequence with no gaps.
REQ-041 Scenario flush: DEPTH=4 holding 2 entries, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0 and out_valid=0, the incoming beat is absent, and the next push appears as the first output.
REQ-042 Scenario reset when full: DEPTH=2 full, assert rst for 1 cycle -> count=0, out_valid=0, out_data=0 and in_ready=0 during rst, then in_ready=1.
REQ-043 Scenario DEPTH=1: out_ready=1 and in_valid held at 1 -> in_ready toggles 1,0,1,0, giving a throughput of one beat per two cycles.

Source files
------------

// File: rtl/pipe_elastic_reg.sv
// Elastic pipeline register: a DEPTH-entry circular buffer between two valid/ready stages.
// Outputs are driven only from state, so in_data never reaches out_data in the same cycle.
module pipe_elastic_reg #(
   parameter int WIDTH = 512,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   input  logic             flush,
   output logic [CW-1:0]    count
);

   localparam int            PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push;
   logic             pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
      if (ptr == LAST_PTR) begin
         return {PW{1'b0}};
      end else begin
         return ptr + PW'(1);
      end
   endfunction

   // Handshake outputs are masked by rst so the block looks empty throughout reset.
   always_comb begin
      in_ready  = (count_q < FULL_CNT) && !rst;
      out_valid = (count_q != {CW{1'b0}}) && !rst;
      out_data  = out_valid ? mem_q[rd_ptr_q] : {WIDTH{1'b0}};
      count     = rst ? {CW{1'b0}} : count_q;
      push      = in_valid && in_ready && !flush;
      pop       = out_valid && out_ready && !flush;
   end

   // Next-state logic: reset and flush both clear the pointers; reset wins by construction.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = in_data;
      end else begin
         mem_d = mem_q;
      end
      if (rst || flush) begin
         rd_ptr_d = {PW{1'b0}};
         wr_ptr_d = {PW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy state.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= {PW{1'b0}};
         wr_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage carries no reset; validity is tracked entirely by count_q.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Directed table-driven bench: four instances (DEPTH 1..4) share one stimulus stream,
// and each table row checks the instance its scenario targets.
module tb_pipe_elastic_reg;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic         in_valid;
   logic         out_ready;
   logic [W-1:0] in_data;

   logic [3:0]   ir;
   logic [3:0]   ov;
   logic [W-1:0] od [4];
   logic [0:0]   c0;
   logic [1:0]   c1;
   logic [1:0]   c2;
   logic [2:0]   c3;
   logic [3:0]   cnt [4];

   assign cnt[0] = {3'b000, c0};
   assign cnt[1] = {2'b00, c1};
   assign cnt[2] = {2'b00, c2};
   assign cnt[3] = {1'b0, c3};

   always #5 clk = ~clk;

   pipe_elastic_reg #(.WIDTH(W), .DEPTH(1)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]),
      .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready), .flush(flush), .count(c0));
   pipe_elastic_reg #(.WIDTH(W), .DEPTH(2)) u_d2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]),
      .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready), .flush(flush), .count(c1));
   pipe_elastic_reg #(.WIDTH(W), .DEPTH(3)) u_d3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[2]),
      .out_valid(ov[2]), .out_data(od[2]), .out_ready(out_ready), .flush(flush), .count(c2));
   pipe_elastic_reg #(.WIDTH(W), .DEPTH(4)) u_d4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[3]),
      .out_valid(ov[3]), .out_data(od[3]), .out_ready(out_ready), .flush(flush), .count(c3));

   typedef struct {
      int           dut;
      logic         r;
      logic         f;
      logic         iv;
      logic [W-1:0] d;
      logic         ordy;
      logic         eir;
      logic         eov;
      logic [W-1:0] eod;
      logic [3:0]   ecnt;
   } vec_t;

   vec_t vq[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic add(input int dut, input logic r, input logic f, input logic iv,
                      input logic [W-1:0] d, input logic ordy, input logic eir,
                      input logic eov, input logic [W-1:0] eod, input logic [3:0] ecnt);
      vec_t v;
      v.dut = dut; v.r = r; v.f = f; v.iv = iv; v.d = d; v.ordy = ordy;
      v.eir = eir; v.eov = eov; v.eod = eod; v.ecnt = ecnt;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

      // Streaming, DEPTH=2: one beat per cycle, count never above 1.
      add(1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 4'd0);
      for (int k = 1; k <= 8; k++) begin
         add(1, 1'b0, 1'b0, 1'b1, W'(k), 1'b1, 1'b1, (k > 1), (k > 1) ? W'(k - 1) : 16'h0,
             (k > 1) ? 4'd1 : 4'd0);
      end
      add(1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h8, 4'd1);
      add(1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0, 4'd0);

      // Backpressure, DEPTH=3: 0xD refused at full, head stays 0xA.
      add(2, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 4'd0);
      add(2, 1'b0, 1'b0, 1'b1, 16'hA, 1'b0, 1'b1, 1'b0, 16'h0, 4'd0);
      add(2, 1'b0, 1'b0, 1'b1, 16'hB, 1'b0, 1'b1, 1'b1, 16'hA, 4'd1);
      add(2, 1'b0, 1'b0, 1'b1, 16'hC, 1'b0, 1'b1, 1'b1, 16'hA, 4'd2);
      add(2, 1'b0, 1'b0, 1'b1, 16'hD, 1'b0, 1'b0, 1'b1, 16'hA, 4'd3);
      add(2, 1'b0, 1'b0, 1'b1, 16'hD, 1'b0, 1'b0, 1'b1, 16'hA, 4'd3);
      add(2, 1'b0, 1'b0, 1'b1, 16'hD, 1'b1, 1'b0, 1'b1, 16'hA, 4'd3);
      add(2, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 16'hB, 4'd2);
      add(2, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 16'hC, 4'd1);
      add(2, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0, 4'd0);

      // Wrap, DEPTH=3: both pointers pass 2->0 twice.
      add(2, 1'b1, 1'b0, 1'b0, 16'h0,  1'b0, 1'b0, 1'b0, 16'h0,  4'd0);
      add(2, 1'b0, 1'b0, 1'b1, 16'h21, 1'b0, 1'b1, 1'b0, 16'h0,  4'd0);
      add(2, 1'b0, 1'b0, 1'b1, 16'h22, 1'b1, 1'b1, 1'b1, 16'h21, 4'd1);
      add(2, 1'b0, 1'b0, 1'b1, 16'h23, 1'b1, 1'b1, 1'b1, 16'h22, 4'd1);
      add(2, 1'b0, 1'b0, 1'b0, 16'h0,  1'b1, 1'b1, 1'b1, 16'h23, 4'd1);
      add(2, 1'b0, 1'b0, 1'b1, 16'h24, 1'b0, 1'b1, 1'b0, 16'h0,  4'd0);
      add(2, 1'b0, 1'b0, 1'b1, 16'h25, 1'b0, 1'b1, 1'b1, 16'h24, 4'd1);
      add(2, 1'b0, 1'b0, 1'b1, 16'h26, 1'b1, 1'b1, 1'b1, 16'h24, 4'd2);
      add(2, 1'b0, 1'b0, 1'b1, 16'h27, 1'b1, 1'b1, 1'b1, 16'h25, 4'd2);
      add(2, 1'b0, 1'b0, 1'b0, 16'h0,  1'b1, 1'b1, 1'b1, 16'h26, 4'd2);
      add(2, 1'b0, 1'b0, 1'b0, 16'h0,  1'b1, 1'b1, 1'b1, 16'h27, 4'd1);
      add(2, 1'b0, 1'b0, 1'b0, 16'h0,  1'b1, 1'b1, 1'b0, 16'h0,  4'd0);

      // Flush, DEPTH=4: 0x33 offered during flush is dropped, 0x34 comes out first.
      add(3, 1'b1, 1'b0, 1'b0, 16'h0,  1'b0, 1'b0, 1'b0, 16'h0,  4'd0);
      add(3, 1'b0, 1'b0, 1'b1, 16'h31, 1'b0, 1'b1, 1'b0, 16'h0,  4'd0);
      add(3, 1'b0, 1'b0, 1'b1, 16'h32, 1'b0, 1'b1, 1'b1, 16'h31, 4'd1);
      add(3, 1'b0, 1'b1, 1'b1, 16'h33, 1'b1, 1'b1, 1'b1, 16'h31, 4'd2);
      add(3, 1'b0, 1'b0, 1'b1, 16'h34, 1'b0, 1'b1, 1'b0, 16'h0,  4'd0);
      add(3, 1'b0, 1'b0, 1'b0, 16'h0,  1'b1, 1'b1, 1'b1, 16'h34, 4'd1);
      add(3, 1'b0, 1'b0, 1'b0, 16'h0,  1'b1, 1'b1, 1'b0, 16'h0,  4'd0);

      // Reset when full, DEPTH=2: outputs cleared during rst, in_ready back right after.
      add(1, 1'b1, 1'b0, 1'b0, 16'h0,  1'b0, 1'b0, 1'b0, 16'h0,  4'd0);
      add(1, 1'b0, 1'b0, 1'b1, 16'h41, 1'b0, 1'b1, 1'b0, 16'h0,  4'd0);
      add(1, 1'b0, 1'b0, 1'b1, 16'h42, 1'b0, 1'b1, 1'b1, 16'h41, 4'd1);
      add(1, 1'b0, 1'b0, 1'b1, 16'h43, 1'b0, 1'b0, 1'b1, 16'h41, 4'd2);
      add(1, 1'b1, 1'b0, 1'b1, 16'h44, 1'b1, 1'b0, 1'b0, 16'h0,  4'd0);
      add(1, 1'b0, 1'b0, 1'b0, 16'h0,  1'b0, 1'b1, 1'b0, 16'h0,  4'd0);
      add(1, 1'b0, 1'b0, 1'b1, 16'h45, 1'b0, 1'b1, 1'b0, 16'h0,  4'd0);
      add(1, 1'b0, 1'b0, 1'b0, 16'h0,  1'b1, 1'b1, 1'b1, 16'h45, 4'd1);
      add(1, 1'b0, 1'b0, 1'b0, 16'h0,  1'b1, 1'b1, 1'b0, 16'h0,  4'd0);

      // DEPTH=1 with in_valid and out_ready held high: in_ready alternates.
      add(0, 1'b1, 1'b0, 1'b0, 16'h0,  1'b1, 1'b0, 1'b0, 16'h0,  4'd0);
      add(0, 1'b0, 1'b0, 1'b1, 16'h51, 1'b1, 1'b1, 1'b0, 16'h0,  4'd0);
      add(0, 1'b0, 1'b0, 1'b1, 16'h52, 1'b1, 1'b0, 1'b1, 16'h51, 4'd1);
      add(0, 1'b0, 1'b0, 1'b1, 16'h52, 1'b1, 1'b1, 1'b0, 16'h0,  4'd0);
      add(0, 1'b0, 1'b0, 1'b1, 16'h53, 1'b1, 1'b0, 1'b1, 16'h52, 4'd1);
      add(0, 1'b0, 1'b0, 1'b1, 16'h53, 1'b1, 1'b1, 1'b0, 16'h0,  4'd0);
      add(0, 1'b0, 1'b0, 1'b0, 16'h0,  1'b1, 1'b0, 1'b1, 16'h53, 4'd1);
      add(0, 1'b0, 1'b0, 1'b0, 16'h0,  1'b1, 1'b1, 1'b0, 16'h0,  4'd0);

      #1;
      foreach (vq[i]) begin
         rst       = vq[i].r;
         flush     = vq[i].f;
         in_valid  = vq[i].iv;
         in_data   = vq[i].d;
         out_ready = vq[i].ordy;
         #1;
         chk("in_ready",  i, 32'(ir[vq[i].dut]),  32'(vq[i].eir));
         chk("out_valid", i, 32'(ov[vq[i].dut]),  32'(vq[i].eov));
         chk("out_data",  i, 32'(od[vq[i].dut]),  32'(vq[i].eod));
         chk("count",     i, 32'(cnt[vq[i].dut]), 32'(vq[i].ecnt));
         @(posedge clk);
         #1;
      end

      // Long stream on DEPTH=2: in_ready must never drop and data follows one cycle behind.
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         in_valid = 1'b1;
         in_data  = 16'h0100 + W'(k);
         #1;
         chk("stream_in_ready", k, 32'(ir[1]), 32'd1);
         if (k > 0) begin
            chk("stream_out_valid", k, 32'(ov[1]), 32'd1);
            chk("stream_out_data",  k, 32'(od[1]), 32'h0100 + 32'(k - 1));
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      #1;
      chk("stream_tail_data", 20, 32'(od[1]), 32'h0113);
      @(posedge clk);
      #1;
      chk("stream_drained", 21, 32'(cnt[1]), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
